// File: rtl/wash_pkg.sv
// wash_pkg: motor command codes, bridge FSM states and default timing shared by the wash motor path
package wash_pkg;
  typedef enum logic [1:0] {MOT_STOP = 2'b00, MOT_FWD = 2'b01, MOT_REV = 2'b10, MOT_BAD = 2'b11} mot_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} state_e;
  localparam int DEAD_CYC_DEF      = 400;
  localparam int PWM_BITS_DEF      = 4;
  localparam int RAMP_STEP_CYC_DEF = 800;
endpackage

// File: rtl/motor_bridge_drv_pwm_gen.sv
// pwm_gen: free-running PWM counter with compare against duty
// ports: clk, rst_n (async active-low); clr holds the counter at 0;
//        duty 0..2^PWM_BITS; pwm = (pwm_cnt < duty), constant 1 at full duty
module pwm_gen
  import wash_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [PWM_BITS:0] duty,
  output logic              pwm
);
  logic [PWM_BITS-1:0] pwm_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pwm_cnt <= '0;
    else pwm_cnt <= clr ? '0 : pwm_cnt + 1'b1;
  assign pwm = {1'b0, pwm_cnt} < duty;
endmodule

// File: rtl/motor_bridge_drv.sv
// motor_bridge_drv: motor command to H-bridge gate enables with dead time and soft-start ramp
// ports: clk, rst_n (async active-low); motor 00 stop / 01 fwd / 10 rev / 11 illegal;
//        hs_a/ls_a/hs_b/ls_b gate enables; running in RUN; ramp_done at full duty;
//        fault sticky on an illegal command, cleared only by rst_n
module motor_bridge_drv
  import wash_pkg::*;
#(
  parameter int DEAD_CYC      = DEAD_CYC_DEF,
  parameter int PWM_BITS      = PWM_BITS_DEF,
  parameter int RAMP_STEP_CYC = RAMP_STEP_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] motor,
  output logic       hs_a,
  output logic       ls_a,
  output logic       hs_b,
  output logic       ls_b,
  output logic       running,
  output logic       ramp_done,
  output logic       fault
);
  localparam int DW = $clog2(DEAD_CYC);
  localparam int RW = $clog2(RAMP_STEP_CYC);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_STEP_CYC - 1);
  localparam logic [PWM_BITS:0] FULL = {1'b1, {PWM_BITS{1'b0}}};
  state_e state, state_nx;
  mot_e cmd;
  logic rev, rev_nx, enter, pwm, run;
  logic [DW-1:0] dead_cnt;
  logic [RW-1:0] ramp_cnt;
  logic [PWM_BITS:0] duty;
  // an illegal code is treated as stop everywhere in the FSM
  assign cmd = (motor == MOT_BAD) ? MOT_STOP : mot_e'(motor);
  assign enter = (state != RUN) && (state_nx == RUN);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rev   <= 1'b0;
    end else begin
      state <= state_nx;
      rev   <= rev_nx;
    end
  // DEAD always runs to completion; only the command at its last cycle matters
  always_comb begin
    state_nx = state;
    rev_nx   = rev;
    case (state)
      IDLE: if (cmd != MOT_STOP) begin
        state_nx = RUN;
        rev_nx   = cmd == MOT_REV;
      end
      RUN: if (cmd != (rev ? MOT_REV : MOT_FWD)) state_nx = DEAD;
      DEAD: if (dead_cnt == DEAD_LAST) begin
        state_nx = (cmd == MOT_STOP) ? IDLE : RUN;
        rev_nx   = cmd == MOT_REV;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dead_cnt <= '0;
      ramp_cnt <= '0;
      duty     <= '0;
      fault    <= 1'b0;
    end else begin
      dead_cnt <= (state == DEAD && state_nx == DEAD) ? dead_cnt + 1'b1 : '0;
      fault    <= fault | (motor == MOT_BAD);
      if (enter || state_nx != RUN) begin
        duty     <= {{PWM_BITS{1'b0}}, enter};
        ramp_cnt <= '0;
      end else if (duty != FULL) begin
        ramp_cnt <= (ramp_cnt == RAMP_LAST) ? '0 : ramp_cnt + 1'b1;
        if (ramp_cnt == RAMP_LAST) duty <= duty + 1'b1;
      end
    end
  pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != RUN),
    .duty (duty),
    .pwm  (pwm)
  );
  // gates decode only from flops, so they carry no combinational path from motor
  always_comb begin
    run       = state == RUN;
    hs_a      = run & ~rev & pwm;
    ls_b      = run & ~rev;
    ls_a      = run & rev;
    hs_b      = run & rev & pwm;
    running   = run;
    ramp_done = run && duty == FULL;
  end
endmodule

// File: tb/tb_motor_bridge_drv.sv
// tb_motor_bridge_drv: scoreboarded random/directed bench for motor_bridge_drv with gate invariant checks
module tb_motor_bridge_drv;
  localparam int DEAD = 400;
  localparam int STEP = 800;
  localparam int PER  = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] motor = 2'b00;
  logic hs_a, ls_a, hs_b, ls_b, running, ramp_done, fault;
  logic [6:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int t, t_ent, t_dead, mode, mdir;
  bit mfault;
  motor_bridge_drv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .motor    (motor),
    .hs_a     (hs_a),
    .ls_a     (ls_a),
    .hs_b     (hs_b),
    .ls_b     (ls_b),
    .running  (running),
    .ramp_done(ramp_done),
    .fault    (fault)
  );
  always #5 clk = ~clk;
  // reference model: time since run entry gives duty and PWM phase directly
  always @(posedge clk) begin
    int cmd, e, duty;
    bit p;
    logic [6:0] x;
    x = '0;
    if (!rst_n) begin
      t = 0; mode = 0; mdir = 0; mfault = 0;
    end else begin
      t++;
      cmd = (motor == 2'd3) ? 0 : int'(motor);
      if (motor == 2'd3) mfault = 1;
      if (mode == 0 && cmd != 0) begin
        mode = 1; mdir = cmd; t_ent = t;
      end else if (mode == 1 && cmd != mdir) begin
        mode = 2; t_dead = t;
      end else if (mode == 2 && t - t_dead == DEAD) begin
        mode = (cmd == 0) ? 0 : 1; mdir = cmd; t_ent = t;
      end
      if (mode == 1) begin
        e = t - t_ent;
        duty = 1 + e / STEP;
        if (duty > PER) duty = PER;
        p = (e % PER) < duty;
        x = (mdir == 1) ? {p, 1'b0, 1'b0, 1'b1, 1'b1, duty == PER, 1'b0}
                        : {1'b0, 1'b1, p, 1'b0, 1'b1, duty == PER, 1'b0};
      end
      x[0] = mfault;
    end
    exp_q.push_back(x);
  end
  // monitor: scoreboard pop, gate invariants, and the async reset check
  initial begin
    int off, last, d;
    logic [6:0] act, e;
    off = 0; last = 0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (clk) begin
        #1;
        act = {hs_a, ls_a, hs_b, ls_b, running, ramp_done, fault};
        compared++;
        if (act !== 7'b0) begin
          mismatched++;
          $display("FAIL async_reset at %0t: outputs=%b required=%b", $time, act, 7'b0);
        end
        exp_q.delete();
        off = 0; last = 0;
      end else begin
        act = {hs_a, ls_a, hs_b, ls_b, running, ramp_done, fault};
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          compared++;
          if (act !== e) begin
            mismatched++;
            $display("FAIL scoreboard at %0t: {hs_a,ls_a,hs_b,ls_b,running,ramp_done,fault} got %b expected %b", $time, act, e);
          end
        end
        compared++;
        if ((hs_a & ls_a) | (hs_b & ls_b) | (hs_a & hs_b) | (ls_a & ls_b)) begin
          mismatched++;
          $display("FAIL gate_combo at %0t: gates=%b required no conflicting pair", $time, act[6:3]);
        end
        if (act[6:3] == 4'b0) off++;
        else begin
          d = ls_b ? 1 : 2;
          if (last != 0 && d != last && off < DEAD) begin
            mismatched++;
            $display("FAIL dead_gap at %0t: all-off cycles=%0d required>=%0d", $time, off, DEAD);
          end
          last = d; off = 0;
        end
      end
    end
  end
  task automatic hold(input logic [1:0] m, input int n);
    motor = m;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int r;
    logic [1:0] m;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(2'b00, 5);
    hold(2'b01, 12100);
    hold(2'b10, 500);
    hold(2'b01, 600);
    hold(2'b00, 200);
    hold(2'b01, 600);
    hold(2'b10, 600);
    hold(2'b11, 3);
    hold(2'b00, 500);
    hold(2'b01, 300);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      m = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      hold(m, $urandom_range(1, 900));
    end
    hold(2'b00, 500);
    hold(2'b01, 300);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold(2'b01, 100);
    hold(2'b00, 10);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
